// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register for the 64-bit ARM pipeline.
// Holds the fetched instruction, its PC and a valid bit, detects load-use
// hazards against the decode slot, applies branch-taken flushes, and keeps
// saturating stall/flush event counters for performance debug.
module if_id_stage_reg #(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] NOP_INSTR = 32'hD503201F
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      if_instruction,
  input  logic [63:0]      if_pc,
  input  logic             pc_src,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  output logic             pc_write,
  output logic [31:0]      id_instruction,
  output logic [63:0]      id_pc,
  output logic             id_valid,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [4:0]       XZR     = 5'd31;

  logic [4:0] rn;
  logic [4:0] rm;
  logic [4:0] rt;
  logic       is_stur;
  logic       is_cbz;
  logic       uses_rt;
  logic       src_match;
  logic       hazard;
  logic       flush;
  logic       stall;

  assign rn      = id_instruction[9:5];
  assign rm      = id_instruction[20:16];
  assign rt      = id_instruction[4:0];
  assign is_stur = (id_instruction[31:21] == 11'b11111000000);
  assign is_cbz  = (id_instruction[31:24] == 8'b10110100);
  assign uses_rt = is_stur | is_cbz;

  // Load-use hazard on the decode slot; rm is always compared (false stalls
  // are harmless), and XZR never creates a dependency.
  always_comb begin
    src_match = (ex_rd == rn) | (ex_rd == rm) | (uses_rt & (ex_rd == rt));
    hazard    = id_valid & ex_mem_read & (ex_rd != XZR) & src_match;
  end

  // A taken branch overrides a stall: the stalled instruction is discarded anyway.
  assign flush     = pc_src;
  assign stall     = hazard & ~flush;
  assign pc_write  = ~stall;
  assign ex_bubble = stall;

  // Decode slot: flush inserts a NOP, stall holds, otherwise capture fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_instruction <= NOP_INSTR;
      id_pc          <= 64'd0;
      id_valid       <= 1'b0;
    end else if (flush) begin
      id_instruction <= NOP_INSTR;
      id_pc          <= if_pc;
      id_valid       <= 1'b0;
    end else if (!stall) begin
      id_instruction <= if_instruction;
      id_pc          <= if_pc;
      id_valid       <= 1'b1;
    end
  end

  // Event counters saturate at all-ones so a long run never reads back as small.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (flush && (flush_count != CNT_MAX)) begin
        flush_count <= flush_count + CNT_ONE;
      end
      if (stall && (stall_count != CNT_MAX)) begin
        stall_count <= stall_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Self-checking bench for if_id_stage_reg: directed scenarios with literal
// expectations plus a randomized stream checked every cycle against a
// behavioural model of the decode slot and counters.
module tb_if_id_stage_reg;

  localparam int          CNT_W   = 4;
  localparam int          CNT_SAT = (1 << CNT_W) - 1;
  localparam logic [31:0] NOP     = 32'hD503201F;

  logic             clk;
  logic             rst;
  logic [31:0]      if_instruction;
  logic [63:0]      if_pc;
  logic             pc_src;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             pc_write;
  logic [31:0]      id_instruction;
  logic [63:0]      id_pc;
  logic             id_valid;
  logic             ex_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  if_id_stage_reg #(.CNT_W(CNT_W), .NOP_INSTR(NOP)) dut (
    .clk            (clk),
    .rst            (rst),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .pc_src         (pc_src),
    .ex_mem_read    (ex_mem_read),
    .ex_rd          (ex_rd),
    .pc_write       (pc_write),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_valid       (id_valid),
    .ex_bubble      (ex_bubble),
    .stall_count    (stall_count),
    .flush_count    (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model of what decode should see.
  logic [31:0] m_instr;
  logic [63:0] m_pc;
  logic        m_valid;
  int          m_stalls;
  int          m_flushes;
  logic        prev_stall;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_instr   = NOP;
    m_pc      = 64'd0;
    m_valid   = 1'b0;
    m_stalls  = 0;
    m_flushes = 0;
    prev_stall = 1'b0;
  endtask

  // Does the loaded register feed any source operand of the slot instruction?
  function automatic bit model_hazard(input logic [31:0] ins, input logic v,
                                      input logic mr, input logic [4:0] rd);
    logic [4:0] srcs[$];
    srcs.push_back(ins[9:5]);
    srcs.push_back(ins[20:16]);
    if (ins[31:21] == 11'h7C0 || ins[31:24] == 8'hB4) srcs.push_back(ins[4:0]);
    if (!v || !mr || rd == 5'd31) return 1'b0;
    foreach (srcs[i]) if (srcs[i] == rd) return 1'b1;
    return 1'b0;
  endfunction

  // One cycle: drive inputs after the falling edge, compare every output with
  // the model, then advance the model to what the next rising edge produces.
  task automatic step(input logic r, input logic [31:0] ins, input logic [63:0] pc,
                      input logic src, input logic mr, input logic [4:0] rd);
    bit hz, st;
    @(negedge clk);
    rst = r; if_instruction = ins; if_pc = pc; pc_src = src; ex_mem_read = mr; ex_rd = rd;
    #1;
    if (!r) model_reset();
    hz = model_hazard(m_instr, m_valid, mr, rd);
    st = hz && !src;
    chk("pc_write", {63'd0, pc_write}, {63'd0, !st});
    chk("ex_bubble", {63'd0, ex_bubble}, {63'd0, st});
    chk("id_instruction", {32'd0, id_instruction}, {32'd0, m_instr});
    chk("id_pc", id_pc, m_pc);
    chk("id_valid", {63'd0, id_valid}, {63'd0, m_valid});
    chk("stall_count", {{(64-CNT_W){1'b0}}, stall_count}, 64'(m_stalls));
    chk("flush_count", {{(64-CNT_W){1'b0}}, flush_count}, 64'(m_flushes));
    if (r) begin
      if (src) begin
        m_instr = NOP; m_valid = 1'b0; m_pc = pc;
        if (m_flushes < CNT_SAT) m_flushes++;
      end else if (st) begin
        if (m_stalls < CNT_SAT) m_stalls++;
      end else begin
        m_instr = ins; m_pc = pc; m_valid = 1'b1;
      end
    end
    prev_stall = st && r;
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    case ($urandom_range(0, 3))
      0:       return {11'h458, pick_reg(), 6'd0, pick_reg(), pick_reg()};
      1:       return {11'h7C0, 9'($urandom), 2'b00, pick_reg(), pick_reg()};
      2:       return {8'hB4, 19'($urandom), pick_reg()};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0; if_instruction = 32'd0; if_pc = 64'd0;
    pc_src = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    model_reset();

    // Reset for three cycles, then release and capture the first instruction.
    repeat (3) step(1'b0, 32'h8B020020, 64'h0, 1'b0, 1'b0, 5'd0);
    chk("rst_instr", {32'd0, id_instruction}, {32'd0, 32'hD503201F});
    chk("rst_pc_write", {63'd0, pc_write}, 64'd1);
    step(1'b1, 32'h8B020020, 64'h0, 1'b0, 1'b0, 5'd0);
    step(1'b1, 32'h8B020023, 64'h4, 1'b0, 1'b0, 5'd0);
    chk("first_instr", {32'd0, id_instruction}, {32'd0, 32'h8B020020});
    chk("first_valid", {63'd0, id_valid}, 64'd1);

    // Load-use: slot ADD X3,X1,X2 with a load to X1.
    step(1'b1, 32'h8B040062, 64'h8, 1'b0, 1'b1, 5'd1);
    chk("lu_pc_write", {63'd0, pc_write}, 64'd0);
    chk("lu_bubble", {63'd0, ex_bubble}, 64'd1);
    step(1'b1, 32'h8B040062, 64'h8, 1'b0, 1'b0, 5'd0);
    chk("lu_held", {32'd0, id_instruction}, {32'd0, 32'h8B020023});
    chk("lu_stall_count", {60'd0, stall_count}, 64'd1);
    step(1'b1, 32'h8B020023, 64'hC, 1'b0, 1'b0, 5'd0);
    chk("lu_next", {32'd0, id_instruction}, {32'd0, 32'h8B040062});

    // XZR and non-matching destination against a slot reading X1/X2.
    step(1'b1, 32'h8B020023, 64'h10, 1'b0, 1'b1, 5'd31);
    chk("xzr_pc_write", {63'd0, pc_write}, 64'd1);
    step(1'b1, 32'hF8000005, 64'h14, 1'b0, 1'b1, 5'd7);
    chk("nomatch_pc_write", {63'd0, pc_write}, 64'd1);
    chk("nomatch_stalls", {60'd0, stall_count}, 64'd1);

    // STUR X5,[X0,#0]: rt is a source.
    step(1'b1, 32'h8B020023, 64'h18, 1'b0, 1'b1, 5'd5);
    chk("stur_pc_write", {63'd0, pc_write}, 64'd0);
    step(1'b1, 32'h8B020023, 64'h18, 1'b0, 1'b0, 5'd0);
    chk("stur_stalls", {60'd0, stall_count}, 64'd2);

    // Flush and hazard together, then back-to-back flushes.
    step(1'b1, 32'h8B020023, 64'h1C, 1'b1, 1'b1, 5'd1);
    chk("fvs_pc_write", {63'd0, pc_write}, 64'd1);
    chk("fvs_bubble", {63'd0, ex_bubble}, 64'd0);
    step(1'b1, 32'h8B020023, 64'h20, 1'b1, 1'b0, 5'd0);
    chk("fvs_nop", {32'd0, id_instruction}, {32'd0, 32'hD503201F});
    chk("fvs_flushes", {60'd0, flush_count}, 64'd1);
    chk("fvs_stalls", {60'd0, stall_count}, 64'd2);
    step(1'b1, 32'h8B020023, 64'h24, 1'b1, 1'b0, 5'd0);
    step(1'b1, 32'h8B020023, 64'h28, 1'b0, 1'b0, 5'd0);
    chk("b2b_flushes", {60'd0, flush_count}, 64'd3);
    chk("b2b_valid", {63'd0, id_valid}, 64'd0);

    // Reset asserted in the middle of a stall cycle.
    step(1'b1, 32'h8B020023, 64'h2C, 1'b0, 1'b1, 5'd2);
    chk("mid_stall", {63'd0, pc_write}, 64'd0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_pc_write", {63'd0, pc_write}, 64'd1);
    chk("mid_rst_valid", {63'd0, id_valid}, 64'd0);
    chk("mid_rst_stalls", {60'd0, stall_count}, 64'd0);
    step(1'b0, 32'h8B020023, 64'h0, 1'b0, 1'b1, 5'd2);
    step(1'b1, 32'h8B020023, 64'h0, 1'b0, 1'b0, 5'd0);

    // Randomized stream against the model.
    for (int i = 0; i < 400; i++) begin
      logic r, s, mr;
      r  = ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 9) == 0);
      mr = prev_stall ? 1'b0 : 1'($urandom_range(0, 1));
      step(r, rand_instr(), {$urandom, $urandom}, s, mr, pick_reg());
    end

    // Saturation: alternate load / stall far past the counter range.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 32'h8B020023, 64'(i * 8), 1'b0, 1'b0, 5'd0);
      step(1'b1, 32'h8B020023, 64'(i * 8 + 4), 1'b0, 1'b1, 5'd1);
    end
    step(1'b1, 32'h8B020023, 64'h0, 1'b0, 1'b0, 5'd0);
    chk("stall_saturated", {60'd0, stall_count}, 64'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
